// File: rtl/pipeline_pkg.sv
// Shared encodings for the overlapped fetch/decode/execute sequencer.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'hE1A00000;

  typedef enum logic [1:0] {
    ADDRESS_SELECT_ALU = 2'b00,
    ADDRESS_SELECT_PC  = 2'b01,
    ADDRESS_SELECT_INC = 2'b10
  } addr_sel_e;

  typedef enum logic [1:0] {
    SEQ_RESET,
    SEQ_PRIME,
    SEQ_RUN
  } seq_state_e;

  // KILL drops the valid flag but keeps the instruction word in place.
  typedef enum logic [1:0] {
    STAGE_HOLD,
    STAGE_LOAD,
    STAGE_FLUSH,
    STAGE_KILL
  } stage_op_e;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Memory/execute/decoder side signals of the pipeline sequencer.
interface pipeline_sequencer_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned COUNT_WIDTH = 16
);
  logic [DATA_WIDTH-1:0]  imem_rdata;
  logic                   imem_ready;
  logic                   ex_busy;
  logic                   ex_branch;
  logic                   hazard;
  logic                   control_reset;
  logic [DATA_WIDTH-1:0]  fd_instr;
  logic                   fd_valid;
  logic [DATA_WIDTH-1:0]  de_instr;
  logic                   de_valid;
  logic                   ex_commit;
  logic [1:0]             address_reg_sel;
  logic                   update_address;
  logic                   pc_write_en;
  logic                   fetch_en;
  logic [COUNT_WIDTH-1:0] retire_count;

  modport master (
    input  imem_rdata, imem_ready, ex_busy, ex_branch, hazard,
    output control_reset, fd_instr, fd_valid, de_instr, de_valid, ex_commit,
           address_reg_sel, update_address, pc_write_en, fetch_en, retire_count
  );

  modport slave (
    output imem_rdata, imem_ready, ex_busy, ex_branch, hazard,
    input  control_reset, fd_instr, fd_valid, de_instr, de_valid, ex_commit,
           address_reg_sel, update_address, pc_write_en, fetch_en, retire_count
  );
endinterface

// File: rtl/pipeline_stage_reg.sv
// One pipeline register: instruction word plus valid flag with hold/load/flush/kill.
module pipeline_stage_reg
  import pipeline_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(NOP_INSTR_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  stage_op_e             op_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic                  valid_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic                  valid_o
);

  logic [DATA_WIDTH-1:0] instr_q;
  logic                  valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      case (op_i)
        STAGE_LOAD: begin
          instr_q <= instr_i;
          valid_q <= valid_i;
        end
        STAGE_FLUSH: begin
          instr_q <= NOP_INSTR;
          valid_q <= 1'b0;
        end
        STAGE_KILL: valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pipeline_sequencer.sv
// Overlapped fetch/decode/execute control sequencer with stall, bubble and branch flush.
module pipeline_sequencer
  import pipeline_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR    = DATA_WIDTH'(NOP_INSTR_DEFAULT),
  parameter int unsigned           RESET_CYCLES = 2,
  parameter int unsigned           COUNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pipeline_sequencer_if.master bus
);

  localparam int unsigned RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  seq_state_e             state_q, state_d;
  logic [RW-1:0]          rst_cnt_q, rst_cnt_d;
  logic [COUNT_WIDTH-1:0] retire_cnt_q, retire_cnt_d;

  stage_op_e              fd_op, de_op;
  logic [DATA_WIDTH-1:0]  fd_instr, de_instr;
  logic                   fd_valid, de_valid;

  logic                   retire, flush, stall, bubble;
  logic                   control_reset, fetch_en, ex_commit, update_address;
  addr_sel_e              sel;

  pipeline_stage_reg #(.DATA_WIDTH(DATA_WIDTH), .NOP_INSTR(NOP_INSTR)) u_fd (
    .clk     (clk),
    .rst_n   (reset_n),
    .op_i    (fd_op),
    .instr_i (bus.imem_rdata),
    .valid_i (1'b1),
    .instr_o (fd_instr),
    .valid_o (fd_valid)
  );

  pipeline_stage_reg #(.DATA_WIDTH(DATA_WIDTH), .NOP_INSTR(NOP_INSTR)) u_de (
    .clk     (clk),
    .rst_n   (reset_n),
    .op_i    (de_op),
    .instr_i (fd_instr),
    .valid_i (fd_valid),
    .instr_o (de_instr),
    .valid_o (de_valid)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= SEQ_RESET;
      rst_cnt_q    <= '0;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  // de_valid is never set outside RUN, so these terms only matter there.
  assign retire = de_valid & ~bus.ex_busy;
  assign flush  = retire & bus.ex_branch;
  assign stall  = de_valid & bus.ex_busy;
  assign bubble = ~flush & ~stall & bus.hazard & fd_valid;

  always_comb begin
    state_d        = state_q;
    rst_cnt_d      = rst_cnt_q;
    control_reset  = 1'b0;
    fetch_en       = 1'b0;
    ex_commit      = 1'b0;
    sel            = ADDRESS_SELECT_INC;
    update_address = 1'b0;
    fd_op          = STAGE_HOLD;
    de_op          = STAGE_HOLD;

    case (state_q)
      SEQ_RESET: begin
        control_reset  = 1'b1;
        sel            = ADDRESS_SELECT_PC;
        update_address = 1'b1;
        if (rst_cnt_q == RW'(RESET_CYCLES - 1)) state_d = SEQ_PRIME;
        else rst_cnt_d = rst_cnt_q + RW'(1);
      end
      SEQ_PRIME: state_d = SEQ_RUN;
      SEQ_RUN: begin
        ex_commit = retire;
        if (flush) begin
          fd_op          = STAGE_FLUSH;
          de_op          = STAGE_FLUSH;
          sel            = ADDRESS_SELECT_ALU;
          update_address = 1'b1;
        end else if (stall) begin
          fd_op = STAGE_HOLD;
        end else if (bubble) begin
          de_op = STAGE_FLUSH;
        end else if (!bus.imem_ready) begin
          de_op = STAGE_LOAD;
          fd_op = STAGE_KILL;
        end else begin
          de_op          = STAGE_LOAD;
          fd_op          = STAGE_LOAD;
          fetch_en       = 1'b1;
          update_address = 1'b1;
        end
      end
      default: state_d = SEQ_RESET;
    endcase
  end

  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (ex_commit) retire_cnt_d = retire_cnt_q + COUNT_WIDTH'(1);
  end

  assign bus.control_reset   = control_reset;
  assign bus.fd_instr        = fd_instr;
  assign bus.fd_valid        = fd_valid;
  assign bus.de_instr        = de_instr;
  assign bus.de_valid        = de_valid;
  assign bus.ex_commit       = ex_commit;
  assign bus.address_reg_sel = sel;
  assign bus.update_address  = update_address;
  assign bus.pc_write_en     = update_address;
  assign bus.fetch_en        = fetch_en;
  assign bus.retire_count    = retire_cnt_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer with a per-cycle behavioural pipeline model.
module tb_pipeline_sequencer;

  localparam int          RC  = 2;
  localparam int          CW  = 4;
  localparam logic [31:0] NOP = 32'hE1A00000;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pipeline_sequencer_if #(.DATA_WIDTH(32), .COUNT_WIDTH(CW)) bus ();

  pipeline_sequencer #(
    .DATA_WIDTH(32), .NOP_INSTR(NOP), .RESET_CYCLES(RC), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase counts clock edges since reset release; pipeline slots as plain variables.
  int          ph;
  logic [31:0] m_fd, m_de;
  bit          m_fdv, m_dev;
  int          m_cnt;
  logic [31:0] commits[$];

  task automatic model_reset();
    ph = 0; m_fd = NOP; m_de = NOP; m_fdv = 0; m_dev = 0; m_cnt = 0;
  endtask

  always @(negedge clk) begin
    bit run, retire, flush, stall, bubble, fetch, upd, creset;
    logic [1:0] esel;
    if (!reset_n) model_reset();
    run    = ph > RC;
    creset = ph < RC;
    retire = run && m_dev && !bus.ex_busy;
    flush  = retire && bus.ex_branch;
    stall  = run && m_dev && bus.ex_busy;
    bubble = run && !flush && !stall && bus.hazard && m_fdv;
    fetch  = run && !flush && !stall && !bubble && bus.imem_ready;
    upd    = creset || flush || fetch;
    esel   = creset ? 2'b01 : (flush ? 2'b00 : 2'b10);

    chk("control_reset", 32'(bus.control_reset), 32'(creset));
    chk("ex_commit", 32'(bus.ex_commit), 32'(retire));
    chk("fetch_en", 32'(bus.fetch_en), 32'(fetch));
    chk("address_reg_sel", 32'(bus.address_reg_sel), 32'(esel));
    chk("update_address", 32'(bus.update_address), 32'(upd));
    chk("pc_write_en", 32'(bus.pc_write_en), 32'(upd));
    chk("fd_valid", 32'(bus.fd_valid), 32'(m_fdv));
    chk("de_valid", 32'(bus.de_valid), 32'(m_dev));
    chk("fd_instr", bus.fd_instr, m_fd);
    chk("de_instr", bus.de_instr, m_de);
    chk("retire_count", 32'(bus.retire_count), 32'(m_cnt % (1 << CW)));

    if (bus.ex_commit === 1'b1) commits.push_back(bus.de_instr);

    if (reset_n) begin
      if (retire) m_cnt++;
      if (flush) begin
        m_fd = NOP; m_fdv = 0; m_de = NOP; m_dev = 0;
      end else if (stall) begin
      end else if (bubble) begin
        m_de = NOP; m_dev = 0;
      end else if (run) begin
        m_de = m_fd; m_dev = m_fdv;
        if (bus.imem_ready) begin
          m_fd = bus.imem_rdata; m_fdv = 1;
        end else m_fdv = 0;
      end
      if (ph <= RC) ph++;
    end
  end

  task automatic drive(input logic [31:0] rd, input bit rdy, input bit busy, input bit br, input bit hz);
    bus.imem_rdata = rd; bus.imem_ready = rdy; bus.ex_busy = busy;
    bus.ex_branch = br; bus.hazard = hz;
  endtask

  task automatic step(input logic [31:0] rd, input bit rdy, input bit busy, input bit br, input bit hz);
    @(posedge clk); #1;
    drive(rd, rdy, busy, br, hz);
  endtask

  localparam logic [31:0] A = 32'hA0000001, B = 32'hA0000002, C = 32'hA0000003;
  localparam logic [31:0] D = 32'hA0000004, E = 32'hA0000005, F = 32'hA0000006;
  localparam logic [31:0] G = 32'hA0000007, G2 = 32'hA0000008;
  localparam logic [31:0] T = 32'hB0000001, U = 32'hB0000002, V = 32'hB0000003;
  localparam logic [31:0] W = 32'hB0000004, X = 32'hB0000005, Y = 32'hB0000006;
  localparam logic [31:0] Z = 32'hB0000007, Z2 = 32'hB0000008, JNK = 32'hDEAD0000;

  initial begin
    logic [31:0] exp_commits[$];
    model_reset();
    reset_n = 1'b0;
    drive(JNK, 1, 1, 1, 1);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;                              // c0: RESET
    #1 chk("c0_control_reset", 32'(bus.control_reset), 1);
    chk("c0_sel_pc", 32'(bus.address_reg_sel), 32'h1);
    step(JNK, 1, 1, 1, 1);                          // c1: RESET
    #1 chk("c1_control_reset", 32'(bus.control_reset), 1);
    step(JNK, 1, 1, 1, 1);                          // c2: PRIME
    #1 chk("c2_control_reset", 32'(bus.control_reset), 0);
    chk("c2_sel_inc", 32'(bus.address_reg_sel), 32'h2);
    chk("c2_update", 32'(bus.update_address), 0);
    chk("c2_fetch", 32'(bus.fetch_en), 0);
    step(A, 1, 0, 0, 0);                            // c3: first fetch
    #1 chk("c3_fetch", 32'(bus.fetch_en), 1);
    step(B, 1, 0, 0, 0);
    #1 chk("c4_fd_valid", 32'(bus.fd_valid), 1);
    chk("c4_de_valid", 32'(bus.de_valid), 0);
    chk("c4_fd_instr", bus.fd_instr, A);
    step(C, 1, 0, 0, 0);
    #1 chk("c5_commit", 32'(bus.ex_commit), 1);
    chk("c5_de_instr", bus.de_instr, A);
    step(D, 1, 0, 0, 0);
    step(E, 1, 0, 0, 0);
    step(F, 1, 0, 0, 0);
    step(G, 1, 1, 0, 0);                            // c9: busy with E in de
    #1 chk("c9_fetch", 32'(bus.fetch_en), 0);
    chk("c9_de_instr", bus.de_instr, E);
    chk("c9_fd_instr", bus.fd_instr, F);
    step(G, 1, 1, 1, 0);                            // branch ignored while busy
    step(G, 1, 1, 0, 0);
    step(G, 1, 0, 0, 0);                            // c12: E retires
    #1 chk("c12_commit", 32'(bus.ex_commit), 1);
    chk("c12_de_instr", bus.de_instr, E);
    step(G2, 1, 0, 1, 0);                           // c13: F retires as branch
    #1 chk("c13_count", 32'(bus.retire_count), 5);
    chk("c13_sel_alu", 32'(bus.address_reg_sel), 32'h0);
    chk("c13_update", 32'(bus.update_address), 1);
    step(T, 1, 0, 0, 0);                            // c14: refill at target
    #1 chk("c14_fd_valid", 32'(bus.fd_valid), 0);
    chk("c14_de_valid", 32'(bus.de_valid), 0);
    chk("c14_de_nop", bus.de_instr, NOP);
    chk("c14_fd_nop", bus.fd_instr, NOP);
    chk("c14_fetch", 32'(bus.fetch_en), 1);
    step(U, 1, 0, 0, 0);
    step(V, 1, 0, 0, 0);
    #1 chk("c16_commit_T", bus.de_instr, T);
    step(W, 1, 0, 0, 1);                            // c17: hazard bubble
    #1 chk("c17_fetch", 32'(bus.fetch_en), 0);
    chk("c17_update", 32'(bus.update_address), 0);
    step(W, 1, 1, 0, 0);                            // busy ignored, de empty
    #1 chk("c18_de_valid", 32'(bus.de_valid), 0);
    chk("c18_fd_instr", bus.fd_instr, V);
    chk("c18_fetch", 32'(bus.fetch_en), 1);
    step(JNK, 0, 0, 0, 0);                          // c19: memory wait
    #1 chk("c19_update", 32'(bus.update_address), 0);
    step(JNK, 0, 0, 0, 0);
    #1 chk("c20_fd_valid", 32'(bus.fd_valid), 0);
    chk("c20_fd_instr", bus.fd_instr, W);
    step(X, 1, 0, 0, 1);                            // hazard ignored, fd empty
    #1 chk("c21_fetch", 32'(bus.fetch_en), 1);
    step(Y, 1, 0, 0, 0);
    step(Z, 1, 0, 0, 0);
    step(Z2, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(32'hC0000000 + 32'(i), 1, 0, 0, 0);

    @(posedge clk); #1;                             // 17 commits done
    chk("wrap_count", 32'(bus.retire_count), 1);
    exp_commits = '{A, B, C, D, E, F, T, U, V, W, X, Y, Z, Z2,
                    32'hC0000000, 32'hC0000001, 32'hC0000002};
    chk("commit_total", 32'(commits.size()), 32'(exp_commits.size()));
    for (int i = 0; i < exp_commits.size() && i < commits.size(); i++)
      chk($sformatf("commit_%0d", i), commits[i], exp_commits[i]);

    reset_n = 1'b0;                                 // mid-stream async reset
    #1 chk("mr_control_reset", 32'(bus.control_reset), 1);
    chk("mr_count", 32'(bus.retire_count), 0);
    chk("mr_commit", 32'(bus.ex_commit), 0);
    chk("mr_fetch", 32'(bus.fetch_en), 0);
    chk("mr_de_valid", 32'(bus.de_valid), 0);
    chk("mr_fd_valid", 32'(bus.fd_valid), 0);
    chk("mr_de_nop", bus.de_instr, NOP);
    chk("mr_sel_pc", 32'(bus.address_reg_sel), 32'h1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    drive(JNK, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(32'hD0000000 + 32'(i), 1, 0, 0, 0);
    @(posedge clk); #1;
    chk("post_reset_count", 32'(bus.retire_count), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
